// File: rtl/downscale_seq_pkg.sv
// Shared types and default geometry for the downscale memory sequencer.
package downscale_seq_pkg;

  localparam int unsigned DEF_SRC_H      = 32;
  localparam int unsigned DEF_SRC_W      = 32;
  localparam int unsigned DEF_DST_H      = 16;
  localparam int unsigned DEF_DST_W      = 16;
  localparam int unsigned DEF_RD_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DS_START,
    ST_DS_WAIT,
    ST_WR,
    ST_DONE
  } seq_state_e;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int unsigned clog2_1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/downscale_addr_gen.sv
// Row-major row/col/linear-index counter with a last-element flag.
module downscale_addr_gen
  import downscale_seq_pkg::*;
#(
  parameter int unsigned H = DEF_DST_H,
  parameter int unsigned W = DEF_DST_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          inc,
  output logic [clog2_1(H)-1:0]         row,
  output logic [clog2_1(W)-1:0]         col,
  output logic [$clog2(H*W)-1:0]        idx,
  output logic                          last_c
);

  localparam int unsigned RW = clog2_1(H);
  localparam int unsigned CW = clog2_1(W);
  localparam int unsigned IW = $clog2(H*W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
      idx <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
      idx <= '0;
    end else if (inc) begin
      idx <= IW'(idx + 1'b1);
      if (col == CW'(W - 1)) begin
        col <= '0;
        row <= RW'(row + 1'b1);
      end else begin
        col <= CW'(col + 1'b1);
      end
    end
  end

  assign last_c = (idx == IW'(H*W - 1));

endmodule

// File: rtl/downscale_mem_sequencer.sv
// Streams a source frame from memory into the downscaler buffer, runs the
// downscaler, then writes the reduced frame back one pixel per cycle.
module downscale_mem_sequencer
  import downscale_seq_pkg::*;
#(
  parameter int unsigned SRC_H      = DEF_SRC_H,
  parameter int unsigned SRC_W      = DEF_SRC_W,
  parameter int unsigned DST_H      = DEF_DST_H,
  parameter int unsigned DST_W      = DEF_DST_W,
  parameter int unsigned RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [31:0]                      perf_cycles,
  output logic                             rd_req,
  output logic [$clog2(SRC_H*SRC_W)-1:0]   rd_addr,
  input  logic                             rd_valid,
  input  logic [7:0]                       rd_data,
  output logic                             wr_en,
  output logic [$clog2(DST_H*DST_W)-1:0]   wr_addr,
  output logic [7:0]                       wr_data,
  output logic                             ds_start,
  input  logic                             ds_done,
  output logic [7:0]                       ds_image_in  [SRC_H][SRC_W],
  input  logic [7:0]                       ds_image_out [DST_H][DST_W]
);

  localparam int unsigned RRW = clog2_1(SRC_H);
  localparam int unsigned RCW = clog2_1(SRC_W);
  localparam int unsigned WRW = clog2_1(DST_H);
  localparam int unsigned WCW = clog2_1(DST_W);
  localparam int unsigned TW  = clog2_1(RD_TIMEOUT);

  seq_state_e       state;
  logic [TW-1:0]    wait_cnt;
  logic [31:0]      cyc_cnt;

  logic [RRW-1:0]   rd_row;
  logic [RCW-1:0]   rd_col;
  logic             rd_last_c;
  logic             rd_clr_c;
  logic             rd_inc_c;

  logic [WRW-1:0]   wr_row;
  logic [WCW-1:0]   wr_col;
  logic             wr_last_c;
  logic             wr_clr_c;
  logic             wr_inc_c;
  logic [WRW-1:0]   wr_nrow_c;
  logic [WCW-1:0]   wr_ncol_c;

  assign rd_clr_c = (state == ST_IDLE) && start;
  assign rd_inc_c = (state == ST_RD_WAIT) && rd_valid && !rd_last_c;
  assign wr_clr_c = (state == ST_DS_WAIT) && ds_done;
  assign wr_inc_c = (state == ST_WR) && !wr_last_c;

  downscale_addr_gen #(.H(SRC_H), .W(SRC_W)) u_rd_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (rd_clr_c),
    .inc    (rd_inc_c),
    .row    (rd_row),
    .col    (rd_col),
    .idx    (rd_addr),
    .last_c (rd_last_c)
  );

  downscale_addr_gen #(.H(DST_H), .W(DST_W)) u_wr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (wr_clr_c),
    .inc    (wr_inc_c),
    .row    (wr_row),
    .col    (wr_col),
    .idx    (wr_addr),
    .last_c (wr_last_c)
  );

  // Write data is registered, so it is fetched for the pixel after the current one.
  always_comb begin
    wr_nrow_c = wr_row;
    wr_ncol_c = WCW'(wr_col + 1'b1);
    if (wr_col == WCW'(DST_W - 1)) begin
      wr_ncol_c = '0;
      wr_nrow_c = WRW'(wr_row + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      perf_cycles <= '0;
      rd_req      <= 1'b0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      ds_start    <= 1'b0;
      wait_cnt    <= '0;
      cyc_cnt     <= '0;
    end else begin
      done     <= 1'b0;
      rd_req   <= 1'b0;
      ds_start <= 1'b0;
      if (state != ST_IDLE && state != ST_DONE)
        cyc_cnt <= cyc_cnt + 32'd1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            cyc_cnt <= '0;
            error   <= 1'b0;
            busy    <= 1'b1;
            rd_req  <= 1'b1;
            state   <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          wait_cnt <= '0;
          state    <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (rd_valid) begin
            if (rd_last_c) begin
              ds_start <= 1'b1;
              state    <= ST_DS_START;
            end else begin
              rd_req <= 1'b1;
              state  <= ST_RD_REQ;
            end
          end else if (wait_cnt == TW'(RD_TIMEOUT - 1)) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            wait_cnt <= TW'(wait_cnt + 1'b1);
          end
        end
        ST_DS_START: begin
          state <= ST_DS_WAIT;
        end
        ST_DS_WAIT: begin
          if (ds_done) begin
            wr_en   <= 1'b1;
            wr_data <= ds_image_out[0][0];
            state   <= ST_WR;
          end
        end
        ST_WR: begin
          if (wr_last_c) begin
            wr_en <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            wr_data <= ds_image_out[wr_nrow_c][wr_ncol_c];
          end
        end
        ST_DONE: begin
          perf_cycles <= cyc_cnt;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Frame buffer is plain storage and survives reset.
  always_ff @(posedge clk) begin
    if (state == ST_RD_WAIT && rd_valid)
      ds_image_in[rd_row][rd_col] <= rd_data;
  end

endmodule

// File: doc/downscale_mem_sequencer.md
DOWNSCALE_MEM_SEQUENCER -- requirements
Module: downscale_mem_sequencer

Interface
REQ-001 Parameters SHALL be: SRC_H, default 32, source rows; SRC_W, default 32, source columns; DST_H, default 16, destination rows; DST_W, default 16, destination columns; RD_TIMEOUT, default 255, maximum cycles waited for rd_valid.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  begin a frame
- busy  out  1  frame in progress
- done  out  1  one-cycle end-of-frame pulse
- error  out  1  set on read timeout
- perf_cycles  out  32  cycles of last frame
- rd_req  out  1  source memory read strobe
- rd_addr  out  $clog2(SRC_H*SRC_W)  source address
- rd_valid  in  1  read data valid
- rd_data  in  8  read data
- wr_en  out  1  destination write strobe
- wr_addr  out  $clog2(DST_H*DST_W)  destination address
- wr_data  out  8  destination data
- ds_start  out  1  downscaler start pulse
- ds_done  in  1  downscaler done
- ds_image_in  out  8 x [SRC_H][SRC_W]  source frame buffer
- ds_image_out  in  8 x [DST_H][DST_W]  downscaled frame

Function
REQ-004 The FSM SHALL have states IDLE, RD_REQ, RD_WAIT, DS_START, DS_WAIT, WR, DONE.
REQ-005 IDLE: start=1 SHALL clear the pixel index, perf_cycles counter and error, and move to RD_REQ next cycle.
REQ-006 RD_REQ: rd_req=1 for exactly one cycle, rd_addr=index (row-major, row*SRC_W+col); next state RD_WAIT.
REQ-007 RD_WAIT: rd_req=0; on rd_valid=1, rd_data SHALL be written to ds_image_in[row][col]. If index=SRC_H*SRC_W-1, go to DS_START; otherwise increment index and go to RD_REQ.
REQ-008 At most one read SHALL be outstanding; rd_valid in any state other than RD_WAIT SHALL be ignored.
REQ-009 If RD_WAIT lasts RD_TIMEOUT cycles without rd_valid, the block SHALL set error=1 (sticky until next start) and go to DONE, skipping downscale and write-back.
REQ-010 DS_START: ds_start=1 for exactly one cycle; next state DS_WAIT.
REQ-011 DS_WAIT: on ds_done=1, go to WR with the write index set to 0; ds_done in any other state SHALL be ignored.
REQ-012 WR: wr_en=1 every cycle, wr_addr=windex, wr_data=ds_image_out[windex/DST_W][windex%DST_W]. After windex=DST_H*DST_W-1, go to DONE; one write SHALL occur per cycle with no gaps.
REQ-013 DONE: done=1 for one cycle, perf_cycles latched, next state IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 perf_cycles SHALL equal the number of cycles from the first RD_REQ cycle through the last WR cycle inclusive. With 1-cycle read latency and N DS_WAIT cycles (including the ds_done cycle), perf_cycles=2*SRC_H*SRC_W+1+N+DST_H*DST_W.
REQ-017 ds_image_in SHALL hold its contents after done until overwritten by the next frame.

Reset
REQ-018 rst SHALL asynchronously force IDLE and set busy=0, done=0, error=0, rd_req=0, wr_en=0, ds_start=0, and all indices, addresses, wr_data and perf_cycles to 0; ds_image_in contents are not reset.
REQ-019 rst asserted mid-frame SHALL abort the frame without asserting done, and no write SHALL occur in the cycle after release.

Structure
REQ-020 A shared package downscale_seq_pkg SHALL hold the state enum, the default dimension constants and RD_TIMEOUT.
REQ-021 One sub-module, downscale_addr_gen (row/col counter with last flag), is natural and SHALL be reused for both the read and write index.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Pattern (i*4+j*2)&0xFF, 1-cycle memory, 32x32 to 16x16: 1024 rd_req pulses at addresses 0..1023, one ds_start, 256 writes at addresses 0..255 matching ds_image_out, done pulse, error=0, perf_cycles matches REQ-016.
- Memory latency 3: exactly one outstanding read at a time, ds_image_in identical to the first scenario.
- rd_valid withheld at address 17 for 255 cycles: error=1, done pulses, zero ds_start and zero wr_en.
- start pulsed during DS_WAIT: ignored; exactly one frame completes.
- rst during WR at windex=100: wr_en=0 immediately, busy=0, no done; a fresh start then completes normally.
- ds_done pulsed while in IDLE or RD_WAIT: no state change.
